// File: rtl/calc_pkg.sv
// Key codes, FSM state encoding and key classification helpers for the calculator sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_CE   = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_ADD  = 4'hC;
    localparam logic [3:0] KEY_EQ   = 4'hD;
    localparam logic [3:0] KEY_RCL  = 4'hE;
    localparam logic [3:0] KEY_SAVE = 4'hF;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_SHOW_RES = 3'd2,
        ST_SEL_SAVE = 3'd3,
        ST_SEL_RCL  = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB);
    endfunction

endpackage

// File: rtl/calc_mem_bank.sv
// Memory slot register file: sync write and sync clear, combinational read.
// Write lands on the clock edge; no flow control, out-of-range addresses are dropped / read as 0.
module calc_mem_bank #(
    parameter int WIDTH  = 8,
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [SLOT_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [SLOT_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [SLOTS];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
        end else if (we_i && (int'(waddr_i) < SLOTS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (int'(raddr_i) < SLOTS) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator: operand entry, add/sub with overflow, result chaining, slot save/recall.
// Registers update on the key-accept edge, ack/upd pulses one cycle later; a held key is taken once.
module calc_sequencer #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 2,
    parameter int MEM_SLOTS  = 4,
    parameter int SLOT_W     = $clog2(MEM_SLOTS)
) (
    input  logic              Clock,
    input  logic              clearIn,
    input  logic              key_valid,
    input  logic [3:0]        tecla,
    output logic              key_ack,
    output logic [WIDTH-1:0]  numberA,
    output logic [WIDTH-1:0]  numberB,
    output logic [WIDTH-1:0]  result,
    output logic              operation,
    output logic              overflow,
    output logic [2:0]        estate,
    output logic              updA,
    output logic              updB,
    output logic              updMem,
    output logic [SLOT_W-1:0] mem_slot
);
    import calc_pkg::*;

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic              key_valid_q, accept;
    state_t            state_q, state_d, ret_q, ret_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic              op_q, op_d, ovf_q, ovf_d, fresh_q, fresh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SLOT_W-1:0] slot_q, slot_d, slot_idx;
    logic              ack_q, upda_q, updb_q, updmem_q;

    logic [WIDTH-1:0]  cur_x, x_d, digit_x, alu_a, alu_bp, alu_sum, mem_wdata, mem_rdata;
    logic [WIDTH+3:0]  mac;
    logic              alu_ovf, slot_ok, mem_we;

    assign accept   = key_valid & ~key_valid_q;
    assign digit_x  = WIDTH'(tecla);
    assign slot_idx = tecla[SLOT_W-1:0];
    assign slot_ok  = int'(tecla) < MEM_SLOTS;
    assign cur_x    = (state_q == ST_ENTER_B) ? b_q : a_q;
    assign mac      = (WIDTH+4)'(cur_x) * (WIDTH+4)'(10) + (WIDTH+4)'(tecla);

    // In SHOW_RES a repeated EQUAL folds B into the previous result again.
    assign alu_a   = (state_q == ST_SHOW_RES) ? res_q : a_q;
    assign alu_bp  = op_q ? (~b_q + WIDTH'(1)) : b_q;
    assign alu_sum = alu_a + alu_bp;
    assign alu_ovf = (alu_a[WIDTH-1] == alu_bp[WIDTH-1]) && (alu_sum[WIDTH-1] != alu_a[WIDTH-1]);

    calc_mem_bank #(.WIDTH(WIDTH), .SLOTS(MEM_SLOTS), .SLOT_W(SLOT_W)) u_mem (
        .clk_i   (Clock),
        .clr_i   (clearIn),
        .we_i    (mem_we),
        .waddr_i (slot_idx),
        .wdata_i (mem_wdata),
        .raddr_i (slot_idx),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        op_d      = op_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        fresh_d   = fresh_q;
        slot_d    = slot_q;
        x_d       = cur_x;
        mem_we    = 1'b0;
        mem_wdata = (ret_q == ST_SHOW_RES) ? res_q : ((ret_q == ST_ENTER_B) ? b_q : a_q);
        if (accept) begin
            case (state_q)
                ST_ENTER_A, ST_ENTER_B: begin
                    if (is_digit(tecla)) begin
                        if (fresh_q) begin
                            x_d     = digit_x;
                            cnt_d   = CNT_W'(1);
                            fresh_d = 1'b0;
                        end else if (int'(cnt_q) < MAX_DIGITS) begin
                            x_d   = WIDTH'(mac);
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (tecla == KEY_CE) begin
                        x_d     = '0;
                        cnt_d   = '0;
                        fresh_d = 1'b1;
                    end else if (is_operator(tecla)) begin
                        op_d = (tecla == KEY_SUB);
                        if (state_q == ST_ENTER_A) begin
                            b_d     = '0;
                            fresh_d = 1'b1;
                            state_d = ST_ENTER_B;
                        end
                    end else if (tecla == KEY_EQ) begin
                        if (state_q == ST_ENTER_B) begin
                            res_d   = alu_sum;
                            ovf_d   = alu_ovf;
                            state_d = ST_SHOW_RES;
                        end
                    end else begin
                        ret_d   = state_q;
                        state_d = (tecla == KEY_SAVE) ? ST_SEL_SAVE : ST_SEL_RCL;
                    end
                    if (state_q == ST_ENTER_B) b_d = x_d;
                    else                       a_d = x_d;
                end
                ST_SHOW_RES: begin
                    if (is_digit(tecla)) begin
                        a_d     = digit_x;
                        b_d     = '0;
                        cnt_d   = CNT_W'(1);
                        fresh_d = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = ST_ENTER_A;
                    end else if (is_operator(tecla)) begin
                        a_d     = res_q;
                        b_d     = '0;
                        op_d    = (tecla == KEY_SUB);
                        cnt_d   = '0;
                        fresh_d = 1'b1;
                        state_d = ST_ENTER_B;
                    end else if (tecla == KEY_EQ) begin
                        a_d   = res_q;
                        res_d = alu_sum;
                        ovf_d = alu_ovf;
                    end else if (tecla != KEY_CE) begin
                        ret_d   = state_q;
                        state_d = (tecla == KEY_SAVE) ? ST_SEL_SAVE : ST_SEL_RCL;
                    end
                end
                ST_SEL_SAVE: begin
                    state_d = ret_q;
                    if (slot_ok) begin
                        mem_we = 1'b1;
                        slot_d = slot_idx;
                    end
                end
                ST_SEL_RCL: begin
                    state_d = ret_q;
                    if (slot_ok) begin
                        slot_d  = slot_idx;
                        fresh_d = 1'b1;
                        cnt_d   = '0;
                        if (ret_q == ST_ENTER_B) b_d = mem_rdata;
                        else                     a_d = mem_rdata;
                        if (ret_q == ST_SHOW_RES) state_d = ST_ENTER_A;
                    end
                end
                default: state_d = ST_ENTER_A;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        key_valid_q <= key_valid;
        if (clearIn) begin
            state_q  <= ST_ENTER_A;
            ret_q    <= ST_ENTER_A;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            op_q     <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            fresh_q  <= 1'b1;
            slot_q   <= '0;
            ack_q    <= 1'b0;
            upda_q   <= 1'b0;
            updb_q   <= 1'b0;
            updmem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            op_q     <= op_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            fresh_q  <= fresh_d;
            slot_q   <= slot_d;
            ack_q    <= accept;
            upda_q   <= accept && (a_d != a_q);
            updb_q   <= accept && (b_d != b_q);
            updmem_q <= mem_we;
        end
    end

    assign key_ack   = ack_q;
    assign numberA   = a_q;
    assign numberB   = b_q;
    assign result    = res_q;
    assign operation = op_q;
    assign overflow  = ovf_q;
    assign estate    = state_q;
    assign updA      = upda_q;
    assign updB      = updb_q;
    assign updMem    = updmem_q;
    assign mem_slot  = slot_q;

endmodule
